// File: rtl/term_accumulator_if.sv
// term_accumulator_if: start/select/term/result handshake bundle between the term accumulator and its neighbours.
interface term_accumulator_if #(
    parameter int SIZE = 16
);
    logic            start;
    logic [2:0]      sel;
    logic [SIZE-1:0] term_in;
    logic            busy;
    logic [SIZE-1:0] result;
    logic            result_valid;
    logic            result_ack;
    logic            overflow;
    modport master (
        output start, term_in, result_ack,
        input  sel, busy, result, result_valid, overflow
    );
    modport slave (
        input  start, term_in, result_ack,
        output sel, busy, result, result_valid, overflow
    );
endinterface

// File: rtl/term_accumulator.sv
// term_accumulator: steps the operand mux select over NUM_TERMS terms and sums them into a signed result with valid/ack.
// Define TERM_ACC_SAT_EN to clamp on signed overflow instead of wrapping.
module term_accumulator #(
    parameter int SIZE      = 16,
    parameter int NUM_TERMS = 8
) (
    input logic               clk,
    input logic               rst_n,
    term_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [2:0] LAST = 3'(NUM_TERMS - 1);
    state_t          r_state;
    logic [2:0]      r_sel;
    logic [SIZE-1:0] r_acc;
    logic            r_valid;
    logic            r_busy;
    logic            r_ovf;
    logic [SIZE-1:0] w_sum;
    logic [SIZE-1:0] w_next;
    logic            w_ovf;
    always_comb begin
        w_sum = r_acc + bus.term_in;
        w_ovf = (r_acc[SIZE-1] == bus.term_in[SIZE-1]) && (w_sum[SIZE-1] != r_acc[SIZE-1]);
`ifdef TERM_ACC_SAT_EN
        w_next = w_ovf ? (r_acc[SIZE-1] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}}) : w_sum;
`else
        w_next = w_sum;
`endif
    end
    // DONE spends one cycle raising valid, so ack is only honoured once valid is visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= ACCUM;
                    r_sel   <= '0;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_busy  <= 1'b1;
                end
                ACCUM: begin
                    r_acc   <= w_next;
                    r_ovf   <= r_ovf | w_ovf;
                    r_sel   <= (r_sel == LAST) ? 3'd0 : r_sel + 3'd1;
                    r_state <= (r_sel == LAST) ? DONE : ACCUM;
                end
                DONE: if (!r_valid) begin
                    r_valid <= 1'b1;
                end else if (bus.result_ack) begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.sel          = r_sel;
    assign bus.result       = r_acc;
    assign bus.result_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_term_accumulator.sv
// tb_term_accumulator: table-driven and randomized checks of term_accumulator against an arithmetic reference model.
module tb_term_accumulator;
    localparam int SIZE = 16;
`ifdef TERM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct {
        logic [15:0] v [8];
        logic [15:0] res;
        logic        ovf;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] mux8 [8];
    logic [15:0] mux1 [8];
    term_accumulator_if #(.SIZE(SIZE)) b8 ();
    term_accumulator_if #(.SIZE(SIZE)) b1 ();
    term_accumulator #(.SIZE(SIZE), .NUM_TERMS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    term_accumulator #(.SIZE(SIZE), .NUM_TERMS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    assign b8.term_in = mux8[b8.sel];
    assign b1.term_in = mux1[b1.sel];
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sum of n signed terms using plain integer arithmetic, wrapped or clamped to 16 bits.
    function automatic logic [16:0] model(input logic [15:0] v [8], input int n);
        int acc;
        int s;
        logic ovf;
        logic [31:0] a;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = acc + int'($signed(v[i]));
            if (s > 32767 || s < -32768) begin
                ovf = 1'b1;
                s = SAT ? (s > 0 ? 32767 : -32768) : (s > 0 ? s - 65536 : s + 65536);
            end
            acc = s;
        end
        a = acc;
        return {ovf, a[15:0]};
    endfunction

    task automatic run8(input logic [15:0] v [8], input logic [15:0] exp_res, input logic exp_ovf, input bit chk_sel);
        int cyc;
        for (int i = 0; i < 8; i++) mux8[i] = v[i];
        @(negedge clk) b8.start = 1'b1;
        @(posedge clk);
        #1 b8.start = 1'b0;
        if (chk_sel) chk("sel_after_start", 32'(b8.sel), 0);
        cyc = 0;
        while (!b8.result_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
            if (chk_sel && cyc <= 8) chk("sel_step", 32'(b8.sel), (cyc == 8) ? 0 : cyc);
        end
        chk("latency", cyc, 9);
        chk("result", 32'(b8.result), 32'(exp_res));
        chk("overflow", 32'(b8.overflow), 32'(exp_ovf));
        b8.result_ack = 1'b1;
        @(posedge clk);
        #1 b8.result_ack = 1'b0;
        chk("valid_after_ack", 32'(b8.result_valid), 0);
        chk("busy_after_ack", 32'(b8.busy), 0);
    endtask

    initial begin
        vec_t tbl [12];
        int cyc;
        int last;
        int n;
        logic prev;
        logic saw;
        b8.start = 1'b0;
        b8.result_ack = 1'b0;
        b1.start = 1'b0;
        b1.result_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mux8[i] = '0;
            mux1[i] = 16'hDEAD;
        end
        for (int i = 0; i < 8; i++) tbl[0].v[i] = 16'(i + 1);
        tbl[0].res = 16'h0024;
        tbl[0].ovf = 1'b0;
        for (int i = 0; i < 8; i++) tbl[1].v[i] = '0;
        tbl[1].v[0] = 16'h7000;
        tbl[1].v[1] = 16'h2000;
        tbl[1].res = SAT ? 16'h7FFF : 16'h9000;
        tbl[1].ovf = 1'b1;
        for (int i = 0; i < 8; i++) tbl[2].v[i] = 16'hFFFF;
        tbl[2].res = 16'hFFF8;
        tbl[2].ovf = 1'b0;
        for (int i = 0; i < 8; i++) tbl[3].v[i] = '0;
        tbl[3].v[0] = 16'h8000;
        tbl[3].v[1] = 16'hFFFF;
        tbl[3].v[2] = 16'h0005;
        tbl[3].res = SAT ? 16'h8005 : 16'h8004;
        tbl[3].ovf = 1'b1;
        for (int k = 4; k < 12; k++) begin
            for (int i = 0; i < 8; i++)
                tbl[k].v[i] = (k % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
            {tbl[k].ovf, tbl[k].res} = model(tbl[k].v, 8);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(b8.sel), 0);
        chk("rst_result", 32'(b8.result), 0);
        chk("rst_valid", 32'(b8.result_valid), 0);
        chk("rst_busy", 32'(b8.busy), 0);
        chk("rst_overflow", 32'(b8.overflow), 0);
        chk("rst_valid_1", 32'(b1.result_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) run8(tbl[k].v, tbl[k].res, tbl[k].ovf, k == 0);
        // valid held while ack low; a start in DONE must not be queued
        for (int i = 0; i < 8; i++) mux8[i] = 16'(i + 1);
        @(negedge clk) b8.start = 1'b1;
        @(posedge clk);
        #1 b8.start = 1'b0;
        cyc = 0;
        while (!b8.result_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("hold_latency", cyc, 9);
        for (int k = 0; k < 5; k++) begin
            b8.start = (k == 2);
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(b8.result_valid), 1);
            chk("hold_result", 32'(b8.result), 36);
            chk("hold_ovf", 32'(b8.overflow), 0);
        end
        b8.start = 1'b0;
        b8.result_ack = 1'b1;
        @(posedge clk);
        #1 b8.result_ack = 1'b0;
        chk("hold_ack_valid", 32'(b8.result_valid), 0);
        repeat (3) @(posedge clk);
        #1 chk("hold_no_queue", 32'(b8.busy), 0);
        run8(tbl[0].v, tbl[0].res, tbl[0].ovf, 1'b0);
        // asynchronous abort in the middle of accumulation
        @(negedge clk) b8.start = 1'b1;
        @(posedge clk);
        #1 b8.start = 1'b0;
        cyc = 0;
        while (b8.sel != 3'd3 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("rst_reach_sel3", 32'(b8.sel), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sel", 32'(b8.sel), 0);
        chk("abort_result", 32'(b8.result), 0);
        chk("abort_valid", 32'(b8.result_valid), 0);
        chk("abort_busy", 32'(b8.busy), 0);
        chk("abort_overflow", 32'(b8.overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 if (b8.result_valid || b8.busy) saw = 1'b1;
        end
        chk("abort_no_partial", 32'(saw), 0);
        run8(tbl[1].v, tbl[1].res, tbl[1].ovf, 1'b0);
        // single-term build
        mux1[0] = 16'h1234;
        @(negedge clk) b1.start = 1'b1;
        @(posedge clk);
        #1 b1.start = 1'b0;
        chk("n1_sel0", 32'(b1.sel), 0);
        @(posedge clk);
        #1;
        chk("n1_sel1", 32'(b1.sel), 0);
        chk("n1_not_yet_valid", 32'(b1.result_valid), 0);
        @(posedge clk);
        #1;
        chk("n1_valid", 32'(b1.result_valid), 1);
        chk("n1_result", 32'(b1.result), 32'h1234);
        chk("n1_overflow", 32'(b1.overflow), 0);
        b1.result_ack = 1'b1;
        b1.start = 1'b1;
        prev = 1'b1;
        last = -1;
        n = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (b1.result_valid && !prev) begin
                if (last >= 0) chk("n1_b2b_interval", c - last, 4);
                last = c;
                n++;
            end
            prev = b1.result_valid;
        end
        chk("n1_b2b_count", n, 4);
        b1.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 b1.result_ack = 1'b0;
        chk("n1_idle", 32'(b1.busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
